pipe_msg_reg: RTL
=================

# pipe_msg_reg

Parametrised pipeline-stage register for the packed per-instruction message bus (instr, pc, operands, tnew, tarReg, grfWE, …) that travels between the D/E/M/W stages. It replaces the hand-written per-stage registers with one generic block that provides:
- stall (hold) and flush (bubble insertion)
- automatic saturating decrement of the tnew field on each advance
- a valid flag per stage
- a saturating hold-cycle counter for the stall-analysis bench

One instance sits between each pair of adjacent pipeline stages.

## Interface
Parameters:
- MSG_W, 256, total message bus width in bits
- TNEW_LSB, 0, bit position of the tnew field's LSB inside the message
- TNEW_W, 4, width of the tnew field
- PC_LSB, 32, bit position of the 32-bit pc field's LSB inside the message
- RESET_PC, 32'h0000_3000, pc value loaded on reset
- DEC_TNEW, 1, 1 = decrement tnew on advance; 0 = pass tnew through unchanged
- CNT_W, 16, width of the hold-cycle counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance: capture msg_in on this edge
- flush  in  1  insert a bubble on this edge; overrides en
- valid_in  in  1  msg_in carries a real instruction
- msg_in  in  MSG_W  message from the upstream stage
- cnt_clr  in  1  synchronous clear of hold_cnt
- valid_out  out  1  msg_out carries a real instruction
- msg_out  out  MSG_W  registered message to the downstream stage
- hold_cnt  out  CNT_W  count of cycles spent holding a valid instruction

## Operation
Reset, asynchronous, any time including mid-hold:
- msg_out = 0, except msg_out[PC_LSB+:32] = RESET_PC
- valid_out = 0, hold_cnt = 0

Per rising edge, priority flush > en > hold:
- **flush=1:**
  - msg_out = 0, except pc field = msg_in pc field (bubble keeps its pc for later exception reporting)
  - valid_out = 0
  - en is ignored
- **flush=0, en=1:**
  - msg_out = msg_in with the tnew field replaced by tnew_next
  - valid_out = valid_in
- **flush=0, en=0:** msg_out and valid_out hold exactly; tnew is not decremented while holding.

tnew_next:
- DEC_TNEW=1: msg_in tnew − 1, saturating at 0 (an input of 0 yields 0, never wraps to all-ones)
- DEC_TNEW=0: msg_in tnew unchanged
- All other fields are copied bit-exact.

hold_cnt:
- cnt_clr=1: hold_cnt = 0 (wins over the increment)
- Else if flush=0, en=0 and valid_out=1: hold_cnt increments by 1, saturating at 2^CNT_W−1
- Otherwise unchanged
- Holding a bubble (valid_out=0) does not count.

Width rules:
- TNEW_LSB+TNEW_W ≤ MSG_W and PC_LSB+32 ≤ MSG_W. Violations are an elaboration error (generate-time check).
- If the tnew field and pc field overlap, this is also an elaboration error.

## Timing
- Latency: 1 cycle, msg_in → msg_out on the edge where en=1 or flush=1.
- Outputs are purely registered; there is no combinational path from any input to any output.
- Reset takes effect immediately on assertion. The first capture happens on the first rising edge after reset deasserts.
- Simultaneous events:
  - flush+en: flush wins
  - cnt_clr during a hold cycle: clear wins, so hold_cnt = 0 that cycle
  - reset overrides everything

## Test plan
- **Reset value:** assert reset mid-hold with hold_cnt=5 -> immediately msg_out=0 except pc=0x00003000, valid_out=0, hold_cnt=0.
- **Advance and decrement:** msg_in tnew=2, pc=0x3004, en=1, valid_in=1 -> next cycle msg_out tnew=1, pc=0x3004, valid_out=1. Repeat with tnew=0 -> tnew=0, not 0xF. Repeat with DEC_TNEW=0 and tnew=2 -> tnew=2.
- **Flush priority:** en=1, flush=1, msg_in pc=0x3010, instr=0x8C410004 -> msg_out instr=0, tnew=0, pc=0x3010, valid_out=0.
- **Hold:** capture a valid instruction, then en=0 for 3 cycles with msg_in changing every cycle -> msg_out is constant, tnew is not decremented, hold_cnt=3.
- **Counter saturation and clear:** CNT_W=4, hold a valid instruction for 20 cycles -> hold_cnt=15. Then cnt_clr=1 during a further hold cycle -> hold_cnt=0 on the next edge.
- **Bubble hold:** flush, then en=0 for 4 cycles -> valid_out=0 and hold_cnt unchanged.

Source files
------------

// File: rtl/pipe_msg_reg.sv
// Generic pipeline-stage register for the packed per-instruction message bus.
// Supports hold, bubble insertion, tnew countdown on advance and a saturating hold-cycle counter.
module pipe_msg_reg #(
  parameter int          MSG_W    = 256,
  parameter int          TNEW_LSB = 0,
  parameter int          TNEW_W   = 4,
  parameter int          PC_LSB   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter bit          DEC_TNEW = 1'b1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [MSG_W-1:0] msg_in,
  input  logic             cnt_clr,
  output logic             valid_out,
  output logic [MSG_W-1:0] msg_out,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [MSG_W-1:0] RESET_MSG = MSG_W'(RESET_PC) << PC_LSB;

  // Field placement is fixed at elaboration, so bad layouts must never build.
  if (TNEW_LSB + TNEW_W > MSG_W) begin : g_bad_tnew
    $error("pipe_msg_reg: tnew field exceeds MSG_W");
  end
  if (PC_LSB + 32 > MSG_W) begin : g_bad_pc
    $error("pipe_msg_reg: pc field exceeds MSG_W");
  end
  if ((TNEW_LSB < PC_LSB + 32) && (PC_LSB < TNEW_LSB + TNEW_W)) begin : g_overlap
    $error("pipe_msg_reg: tnew and pc fields overlap");
  end

  logic [TNEW_W-1:0] tnew_in;
  logic [TNEW_W-1:0] tnew_next;
  logic [MSG_W-1:0]  msg_cap;
  logic [MSG_W-1:0]  msg_bub;

  always_comb begin
    tnew_in = msg_in[TNEW_LSB +: TNEW_W];
    if (DEC_TNEW && (tnew_in != '0)) begin
      tnew_next = tnew_in - TNEW_W'(1);
    end else begin
      tnew_next = tnew_in;
    end
    msg_cap = msg_in;
    msg_cap[TNEW_LSB +: TNEW_W] = tnew_next;
    // A bubble keeps its pc so a later exception can still be attributed.
    msg_bub = '0;
    msg_bub[PC_LSB +: 32] = msg_in[PC_LSB +: 32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_out   <= RESET_MSG;
      valid_out <= 1'b0;
    end else if (flush) begin
      msg_out   <= msg_bub;
      valid_out <= 1'b0;
    end else if (en) begin
      msg_out   <= msg_cap;
      valid_out <= valid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (cnt_clr) begin
      hold_cnt <= '0;
    end else if (!flush && !en && valid_out && (hold_cnt != '1)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule
